// File: rtl/ring_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ring_sched_pkg : shared state encoding and width helper
// Rev 1.0
// ------------------------------------------------------------------
package ring_sched_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  // Never returns 0 so that a value range of 1 still yields a legal 1-bit vector.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_priority_pick : first set request at or above ptr, wrapping
// Rev 1.0
// ------------------------------------------------------------------
module rr_priority_pick
  import ring_sched_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            ptr,
  output logic [N-1:0]            onehot,
  output logic [clog2w(N)-1:0]    idx,
  output logic                    any
);

  localparam int IDXW = clog2w(N);

  logic [IDXW-1:0] pos;
  logic [IDXW-1:0] first;
  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;

  always_comb begin
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) pos = IDXW'(i);
    end
  end

  // Doubling the vector turns the wrapping rotation into a plain part-select.
  assign dbl = {req, req};
  assign rot = dbl[pos +: N];
  assign any = |req;

  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = IDXW'(i);
    end
  end

  always_comb begin
    idx    = IDXW'((int'(pos) + int'(first)) % N);
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/ring_rr_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// ring_rr_scheduler : round-robin scheduler with hold limit and ring pointer
// Rev 1.0
// ------------------------------------------------------------------
module ring_rr_scheduler
  import ring_sched_pkg::*;
#(
  parameter int N        = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   enable,
  input  logic [N-1:0]           req,
  input  logic                   owner_release,
  output logic [N-1:0]           grant,
  output logic                   grant_valid,
  output logic [clog2w(N)-1:0]   grant_idx,
  output logic                   timeout,
  output logic [N-1:0]           ptr
);

  localparam int IDXW = clog2w(N);
  localparam int HW   = clog2w(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          state, state_nxt;
  logic [HW-1:0]   hold, hold_nxt;
  logic [N-1:0]    grant_nxt, ptr_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic            valid_nxt, timeout_nxt;

  logic [N-1:0]    pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  logic start, end_release, end_timeout;

  rr_priority_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign start       = enable & pick_any;
  // Owner dropping its request and an explicit release are the same event.
  assign end_release = owner_release | ~|(req & grant);
  assign end_timeout = ~end_release & (hold == HOLD_LAST);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= ST_IDLE;
      hold        <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
      ptr         <= N'(1);
    end else begin
      state       <= state_nxt;
      hold        <= hold_nxt;
      grant       <= grant_nxt;
      grant_valid <= valid_nxt;
      grant_idx   <= idx_nxt;
      timeout     <= timeout_nxt;
      ptr         <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_GRANT;
      ST_GRANT: if (end_release || end_timeout) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_nxt   = '0;
    valid_nxt   = 1'b0;
    idx_nxt     = '0;
    timeout_nxt = 1'b0;
    hold_nxt    = '0;
    ptr_nxt     = ptr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          grant_nxt = pick_onehot;
          valid_nxt = 1'b1;
          idx_nxt   = pick_idx;
        end
      end
      ST_GRANT: begin
        if (end_release || end_timeout) begin
          // Rotating the held one-hot grant gives one-hot of (grant_idx+1) mod N.
          ptr_nxt     = {grant[N-2:0], grant[N-1]};
          timeout_nxt = end_timeout;
        end else begin
          grant_nxt = grant;
          valid_nxt = 1'b1;
          idx_nxt   = grant_idx;
          hold_nxt  = hold + HW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ring_rr_scheduler : directed scoreboard bench for ring_rr_scheduler
// Rev 1.0
// ------------------------------------------------------------------
module tb_ring_rr_scheduler;

  localparam int N        = 5;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         clear_n;
  logic         enable;
  logic [N-1:0] req;
  logic         owner_release;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_idx;
  logic         timeout;
  logic [N-1:0] ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] grant;
    logic [2:0]   idx;
    logic         tmo;
    logic [N-1:0] ptr;
  } exp_t;

  exp_t sb[$];

  ring_rr_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .enable        (enable),
    .req           (req),
    .owner_release (owner_release),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .timeout       (timeout),
    .ptr           (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [N-1:0] g, input int idx,
                      input logic tmo, input logic [N-1:0] p);
    exp_t e;
    e.tag   = tag;
    e.grant = g;
    e.idx   = 3'(idx);
    e.tmo   = tmo;
    e.ptr   = p;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [N-1:0] g, input int idx,
                           input logic tmo, input logic [N-1:0] p);
    chk({tag, ".grant"},   32'(grant),       32'(g));
    chk({tag, ".valid"},   32'(grant_valid), 32'(|g));
    chk({tag, ".idx"},     32'(grant_idx),   32'(idx));
    chk({tag, ".timeout"}, 32'(timeout),     32'(tmo));
    chk({tag, ".ptr"},     32'(ptr),         32'(p));
  endtask

  // Advance one edge and compare the DUT against the oldest scoreboard entry.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check_now(e.tag, e.grant, int'(e.idx), e.tmo, e.ptr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] g;
    clear_n       = 1'b1;
    enable        = 1'b0;
    req           = '0;
    owner_release = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #3 clear_n = 1'b0;
    #1 check_now("reset_async", 5'b00000, 0, 1'b0, 5'b00001);
    #14 clear_n = 1'b1;
    push("reset_idle", 5'b00000, 0, 1'b0, 5'b00001); tick();

    // Single requester, released on its third grant cycle.
    req = 5'b00100; enable = 1'b1;
    push("single_c1", 5'b00100, 2, 1'b0, 5'b00001); tick();
    push("single_c2", 5'b00100, 2, 1'b0, 5'b00001); tick();
    push("single_c3", 5'b00100, 2, 1'b0, 5'b00001); tick();
    owner_release = 1'b1;
    push("single_rel", 5'b00000, 0, 1'b0, 5'b01000); tick();
    owner_release = 1'b0; req = '0;
    push("single_idle", 5'b00000, 0, 1'b0, 5'b01000); tick();

    // Fresh reset so fairness starts from requester 0.
    clear_n = 1'b0;
    #1 clear_n = 1'b1;
    req = 5'b11111; owner_release = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = 5'b00001 << (k % N);
      push($sformatf("fair_g%0d", k), g, k % N, 1'b0, g); tick();
      push($sformatf("fair_i%0d", k), 5'b00000, 0, 1'b0, 5'b00001 << ((k + 1) % N)); tick();
    end
    req = '0; owner_release = 1'b0;

    // Hold limit: exactly MAX_HOLD grant cycles, then a one-cycle timeout.
    req = 5'b01000;
    for (int c = 0; c < MAX_HOLD; c++) begin
      push($sformatf("hold_c%0d", c), 5'b01000, 3, 1'b0, 5'b00010); tick();
    end
    push("timeout_pulse", 5'b00000, 0, 1'b1, 5'b10000); tick();
    push("timeout_regrant", 5'b01000, 3, 1'b0, 5'b10000); tick();

    // Wrap priority from ptr=10000.
    owner_release = 1'b1; req = 5'b10001;
    push("wrap_end3", 5'b00000, 0, 1'b0, 5'b10000); tick();
    owner_release = 1'b0;
    push("wrap_10001", 5'b10000, 4, 1'b0, 5'b10000); tick();
    owner_release = 1'b1;
    push("wrap_end4", 5'b00000, 0, 1'b0, 5'b00001); tick();
    owner_release = 1'b0; req = 5'b01000;
    push("wrap_pre3", 5'b01000, 3, 1'b0, 5'b00001); tick();
    owner_release = 1'b1; req = 5'b00011;
    push("wrap_end3b", 5'b00000, 0, 1'b0, 5'b10000); tick();
    owner_release = 1'b0;
    push("wrap_00011", 5'b00001, 0, 1'b0, 5'b10000); tick();
    owner_release = 1'b1; req = '0;
    push("wrap_end0", 5'b00000, 0, 1'b0, 5'b00010); tick();
    owner_release = 1'b0;

    // enable low during a grant only blocks the next grant.
    req = 5'b00010;
    push("en_grant", 5'b00010, 1, 1'b0, 5'b00010); tick();
    enable = 1'b0;
    push("en_hold1", 5'b00010, 1, 1'b0, 5'b00010); tick();
    push("en_hold2", 5'b00010, 1, 1'b0, 5'b00010); tick();
    owner_release = 1'b1;
    push("en_rel", 5'b00000, 0, 1'b0, 5'b00100); tick();
    owner_release = 1'b0;
    push("en_blocked1", 5'b00000, 0, 1'b0, 5'b00100); tick();
    push("en_blocked2", 5'b00000, 0, 1'b0, 5'b00100); tick();
    enable = 1'b1;
    push("en_regrant", 5'b00010, 1, 1'b0, 5'b00100); tick();

    // Reset mid-grant takes effect without a clock edge.
    clear_n = 1'b0;
    #1 check_now("reset_midgrant", 5'b00000, 0, 1'b0, 5'b00001);
    clear_n = 1'b1; req = '0;
    push("post_reset_idle", 5'b00000, 0, 1'b0, 5'b00001); tick();

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
